// File: rtl/alarm_bank.sv
// alarm_bank: N_ALARMS programmable alarms, each with a ring/snooze/timeout FSM stepped by min_tick.
// One-cycle event-to-output latency, no flow control; snooze logic only built with `ALARM_SNOOZE_EN.
module alarm_bank #(
   parameter int N_ALARMS   = 4,
   parameter int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
   parameter int SNOOZE_MIN = 9,
   parameter int RING_MIN   = 5,
   parameter int MAX_SNOOZE = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                min_tick,
   input  logic [6:0]          tmin,
   input  logic [6:0]          thrs,
   input  logic [6:0]          tday,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [6:0]          wr_min,
   input  logic [6:0]          wr_hrs,
   input  logic [6:0]          wr_days,
   input  logic                wr_on,
   input  logic                snooze,
   input  logic                dismiss,
   output logic                buzz,
   output logic [N_ALARMS-1:0] ringing,
   output logic [N_ALARMS-1:0] snoozed,
   output logic [N_ALARMS-1:0] missed,
   output logic [IDX_W-1:0]    ring_idx
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RING = 2'd1,
      S_SNZ  = 2'd2
   } state_t;

   localparam logic [6:0] L_RING_MIN = 7'(RING_MIN);

   if (N_ALARMS < 1 || N_ALARMS > 16 || SNOOZE_MIN < 1 || SNOOZE_MIN > 127 ||
       RING_MIN < 1 || RING_MIN > 127 || MAX_SNOOZE < 0 || MAX_SNOOZE > 15) begin : g_param_chk
      $error("alarm_bank: parameter out of range");
   end

   state_t              r_state     [N_ALARMS];
   state_t              w_state_nxt [N_ALARMS];
   logic [6:0]          r_cnt       [N_ALARMS];
   logic [6:0]          w_cnt_nxt   [N_ALARMS];
   logic [N_ALARMS-1:0] r_missed;
   logic [N_ALARMS-1:0] w_missed_nxt;

   logic [6:0]          r_min  [N_ALARMS];
   logic [6:0]          r_hrs  [N_ALARMS];
   logic [6:0]          r_days [N_ALARMS];
   logic [N_ALARMS-1:0] r_on;

   logic [N_ALARMS-1:0] w_wr_sel;
   logic [N_ALARMS-1:0] w_match;
   logic                w_day_ok;

`ifdef ALARM_SNOOZE_EN
   localparam logic [6:0] L_SNOOZE_MIN = 7'(SNOOZE_MIN);
   localparam logic [3:0] L_MAX_SNOOZE = 4'(MAX_SNOOZE);

   logic [3:0]          r_bud     [N_ALARMS];
   logic [3:0]          w_bud_nxt [N_ALARMS];
`else
   logic                w_unused_snooze;
   assign w_unused_snooze = snooze;
`endif

   // Match is evaluated against the configuration held before any same-cycle write.
   assign w_day_ok = (tday <= 7'd6);

   always_comb begin
      for (int i = 0; i < N_ALARMS; i++) begin
         w_wr_sel[i] = wr_en && (wr_idx == IDX_W'(i));
         w_match[i]  = r_on[i] && min_tick && w_day_ok &&
                       (tmin == r_min[i]) && (thrs == r_hrs[i]) && r_days[i][tday[2:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_ALARMS; i++) begin
            r_min[i]  <= '0;
            r_hrs[i]  <= '0;
            r_days[i] <= '0;
         end
         r_on <= '0;
      end else begin
         for (int i = 0; i < N_ALARMS; i++) begin
            if (w_wr_sel[i]) begin
               r_min[i]  <= wr_min;
               r_hrs[i]  <= wr_hrs;
               r_days[i] <= wr_days;
               r_on[i]   <= wr_on;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_ALARMS; i++) begin
            r_state[i] <= S_IDLE;
            r_cnt[i]   <= '0;
`ifdef ALARM_SNOOZE_EN
            r_bud[i]   <= '0;
`endif
         end
         r_missed <= '0;
      end else begin
         for (int i = 0; i < N_ALARMS; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
`ifdef ALARM_SNOOZE_EN
            r_bud[i]   <= w_bud_nxt[i];
`endif
         end
         r_missed <= w_missed_nxt;
      end
   end

   // The counter counts up while ringing and down while snoozed.
   always_comb begin
      w_missed_nxt = r_missed;
      for (int i = 0; i < N_ALARMS; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
`ifdef ALARM_SNOOZE_EN
         w_bud_nxt[i]   = r_bud[i];
`endif
         if (w_wr_sel[i]) begin
            w_state_nxt[i]  = S_IDLE;
            w_missed_nxt[i] = 1'b0;
         end else begin
            case (r_state[i])
               S_IDLE: begin
                  if (!dismiss && w_match[i]) begin
                     w_state_nxt[i] = S_RING;
                     w_cnt_nxt[i]   = '0;
`ifdef ALARM_SNOOZE_EN
                     w_bud_nxt[i]   = L_MAX_SNOOZE;
`endif
                  end
               end
               S_RING: begin
                  if (dismiss) begin
                     w_state_nxt[i] = S_IDLE;
`ifdef ALARM_SNOOZE_EN
                  end else if (snooze) begin
                     if (r_bud[i] != 4'd0) begin
                        w_state_nxt[i] = S_SNZ;
                        w_cnt_nxt[i]   = L_SNOOZE_MIN;
                        w_bud_nxt[i]   = r_bud[i] - 4'd1;
                     end else begin
                        w_state_nxt[i] = S_IDLE;
                     end
`endif
                  end else if (min_tick) begin
                     w_cnt_nxt[i] = r_cnt[i] + 7'd1;
                     if (w_cnt_nxt[i] == L_RING_MIN) begin
                        w_state_nxt[i]  = S_IDLE;
                        w_cnt_nxt[i]    = '0;
                        w_missed_nxt[i] = 1'b1;
                     end
                  end
               end
`ifdef ALARM_SNOOZE_EN
               S_SNZ: begin
                  if (dismiss) begin
                     w_state_nxt[i] = S_IDLE;
                  end else if (min_tick) begin
                     if (r_cnt[i] == 7'd1) begin
                        w_state_nxt[i] = S_RING;
                        w_cnt_nxt[i]   = '0;
                     end else begin
                        w_cnt_nxt[i] = r_cnt[i] - 7'd1;
                     end
                  end
               end
`endif
               default: begin
                  w_state_nxt[i] = S_IDLE;
               end
            endcase
         end
      end
   end

   // Scanning downward leaves the lowest ringing index in ring_idx.
   always_comb begin
      ringing  = '0;
      snoozed  = '0;
      ring_idx = '0;
      for (int i = N_ALARMS - 1; i >= 0; i--) begin
         ringing[i] = (r_state[i] == S_RING);
`ifdef ALARM_SNOOZE_EN
         snoozed[i] = (r_state[i] == S_SNZ);
`endif
         if (r_state[i] == S_RING) begin
            ring_idx = IDX_W'(i);
         end
      end
      buzz = |ringing;
   end

   assign missed = r_missed;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: directed scenarios plus randomized traffic against a minute-level model.
`timescale 1ns/1ps
module tb_alarm_bank;
   localparam int N    = 4;
   localparam int SNZ  = 9;
   localparam int RING = 5;
   localparam int MAXS = 3;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       min_tick;
   logic [6:0] tmin, thrs, tday;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [6:0] wr_min, wr_hrs, wr_days;
   logic       wr_on, snooze, dismiss;
   logic       buzz;
   logic [3:0] ringing, snoozed, missed;
   logic [1:0] ring_idx;

   alarm_bank #(.N_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_MIN(RING), .MAX_SNOOZE(MAXS)) dut (
      .clk(clk), .rst(rst), .min_tick(min_tick), .tmin(tmin), .thrs(thrs), .tday(tday),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_min(wr_min), .wr_hrs(wr_hrs), .wr_days(wr_days),
      .wr_on(wr_on), .snooze(snooze), .dismiss(dismiss), .buzz(buzz), .ringing(ringing),
      .snoozed(snoozed), .missed(missed), .ring_idx(ring_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       tk;
      logic [6:0] tm, th, td;
      logic       we;
      logic [1:0] wi;
      logic [6:0] wm, wh, wd;
      logic       won, sn, ds;
   } stim_t;

   typedef struct packed {
      logic       bz;
      logic [3:0] rg, sz, ms;
      logic [1:0] ix;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: mode 0 = quiet, 1 = ringing, 2 = snoozed.
   int       md_mode [N];
   int       md_rang [N];
   int       md_left [N];
   int       md_bud  [N];
   int       md_min  [N];
   int       md_hrs  [N];
   bit [6:0] md_days [N];
   bit       md_on   [N];
   bit       md_missed [N];

   function automatic void model_reset();
      for (int c = 0; c < N; c++) begin
         md_mode[c] = 0; md_rang[c] = 0; md_left[c] = 0; md_bud[c] = 0;
         md_min[c] = 0; md_hrs[c] = 0; md_days[c] = '0; md_on[c] = 0; md_missed[c] = 0;
      end
   endfunction

   function automatic void model_step(input stim_t s);
      bit hit;
      for (int c = 0; c < N; c++) begin
         hit = md_on[c] && s.tk && (int'(s.tm) == md_min[c]) && (int'(s.th) == md_hrs[c])
               && (s.td <= 7'd6) && md_days[c][s.td[2:0]];
         if (s.we && int'(s.wi) == c) begin
            md_min[c] = int'(s.wm); md_hrs[c] = int'(s.wh); md_days[c] = s.wd; md_on[c] = s.won;
            md_mode[c] = 0; md_missed[c] = 0;
         end else if (md_mode[c] == 0) begin
            if (hit && !s.ds) begin
               md_mode[c] = 1; md_rang[c] = 0; md_bud[c] = MAXS;
            end
         end else if (md_mode[c] == 1) begin
            if (s.ds) md_mode[c] = 0;
            else if (SNZ_EN && s.sn) begin
               if (md_bud[c] > 0) begin
                  md_mode[c] = 2; md_left[c] = SNZ; md_bud[c] = md_bud[c] - 1;
               end else md_mode[c] = 0;
            end else if (s.tk) begin
               md_rang[c] = md_rang[c] + 1;
               if (md_rang[c] == RING) begin md_mode[c] = 0; md_missed[c] = 1; end
            end
         end else begin
            if (s.ds) md_mode[c] = 0;
            else if (s.tk) begin
               md_left[c] = md_left[c] - 1;
               if (md_left[c] == 0) begin md_mode[c] = 1; md_rang[c] = 0; end
            end
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      bit   found;
      e = '0;
      found = 0;
      for (int c = 0; c < N; c++) begin
         e.rg[c] = (md_mode[c] == 1);
         e.sz[c] = (md_mode[c] == 2);
         e.ms[c] = md_missed[c];
         if (md_mode[c] == 1 && !found) begin e.ix = 2'(c); found = 1; end
      end
      e.bz = found;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
      end
   endtask

   function automatic stim_t idle_s();
      stim_t s;
      s = '0;
      s.td = 7'd7;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      min_tick = s.tk; tmin = s.tm; thrs = s.th; tday = s.td;
      wr_en = s.we; wr_idx = s.wi; wr_min = s.wm; wr_hrs = s.wh; wr_days = s.wd; wr_on = s.won;
      snooze = s.sn; dismiss = s.ds;
   endtask

   task automatic cyc(input stim_t s);
      @(negedge clk);
      drive(s);
      model_step(s);
      exp_q.push_back(model_out());
   endtask

   task automatic nop();
      cyc(idle_s());
   endtask

   task automatic tick(input int m, input int h, input int d);
      stim_t s;
      s = idle_s();
      s.tk = 1'b1; s.tm = 7'(m); s.th = 7'(h); s.td = 7'(d);
      cyc(s);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick(0, 0, 7);
   endtask

   task automatic wr(input int idx, input int m, input int h, input logic [6:0] days, input logic on);
      stim_t s;
      s = idle_s();
      s.we = 1'b1; s.wi = 2'(idx); s.wm = 7'(m); s.wh = 7'(h); s.wd = days; s.won = on;
      cyc(s);
   endtask

   task automatic snz();
      stim_t s;
      s = idle_s();
      s.sn = 1'b1;
      cyc(s);
   endtask

   task automatic dis();
      stim_t s;
      s = idle_s();
      s.ds = 1'b1;
      cyc(s);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_buzz"},     16'(buzz),     16'h0);
      chk({tag, "_ringing"},  16'(ringing),  16'h0);
      chk({tag, "_snoozed"},  16'(snoozed),  16'h0);
      chk({tag, "_missed"},   16'(missed),   16'h0);
      chk({tag, "_ring_idx"}, 16'(ring_idx), 16'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(idle_s());
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: one expected entry per driven cycle, compared after the following rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("buzz",     16'(buzz),     16'(e.bz));
            chk("ringing",  16'(ringing),  16'(e.rg));
            chk("snoozed",  16'(snoozed),  16'(e.sz));
            chk("missed",   16'(missed),   16'(e.ms));
            chk("ring_idx", 16'(ring_idx), 16'(e.ix));
         end
      end
   end

   initial begin
      stim_t s;
      rst = 1'b1;
      drive(idle_s());
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic trigger and day mask
      wr(0, 30, 7, 7'b0111110, 1'b1);
      tick(30, 7, 1);
      nop();
      dis();
      tick(30, 7, 0);
      nop();

      // Snooze cycle with budget exhaustion (ignored when snooze is not built)
      tick(30, 7, 2);
      snz();
      snz();
      ticks(SNZ);
      nop();
      snz();
      ticks(SNZ);
      snz();
      ticks(SNZ);
      snz();
      nop();
      dis();

      // Unattended timeout then write clears missed
      wr(1, 0, 8, 7'h7f, 1'b1);
      tick(0, 8, 3);
      ticks(RING);
      nop();
      wr(1, 0, 8, 7'h7f, 1'b1);
      nop();

      // Two channels at once, dismiss, dismiss with snooze
      wr(0, 0, 6, 7'h7f, 1'b1);
      wr(2, 0, 6, 7'h7f, 1'b1);
      tick(0, 6, 4);
      nop();
      dis();
      tick(0, 6, 5);
      snz();
      s = idle_s(); s.sn = 1'b1; s.ds = 1'b1;
      cyc(s);
      nop();

      // Write in the same cycle as a match
      wr(0, 15, 9, 7'h7f, 1'b1);
      s = idle_s();
      s.tk = 1'b1; s.tm = 7'd15; s.th = 7'd9; s.td = 7'd3;
      s.we = 1'b1; s.wi = 2'd0; s.wm = 7'd15; s.wh = 7'd9; s.wd = 7'h7f; s.won = 1'b1;
      cyc(s);
      nop();

      // Reset while ringing with a missed flag set
      wr(3, 20, 9, 7'h7f, 1'b1);
      tick(20, 9, 3);
      ticks(RING);
      tick(15, 9, 3);
      nop();
      do_reset();
      nop();
      tick(15, 9, 3);

      // Randomized traffic
      for (int c = 0; c < N; c++)
         wr(c, $urandom_range(0, 3), $urandom_range(6, 7), 7'($urandom), 1'b1);
      for (int k = 0; k < 3000; k++) begin
         s = idle_s();
         s.tk = ($urandom_range(0, 1) == 1);
         s.tm = 7'($urandom_range(0, 3));
         s.th = 7'($urandom_range(6, 7));
         s.td = 7'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) begin
            s.we = 1'b1;
            s.wi = 2'($urandom_range(0, 3));
            s.wm = 7'($urandom_range(0, 3));
            s.wh = 7'($urandom_range(6, 7));
            s.wd = 7'($urandom);
            s.won = ($urandom_range(0, 9) != 0);
         end
         if (!s.tk) begin
            if ($urandom_range(0, 99) < 8) s.sn = 1'b1;
            else if ($urandom_range(0, 99) < 5) s.ds = 1'b1;
         end
         cyc(s);
      end

      @(negedge clk);
      drive(idle_s());
      @(posedge clk);
      #2;
      chk("queue_drained", 16'(exp_q.size()), 16'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
